// File: rtl/rgb_sobel_edge_if.sv
// Pixel-clock RGB video stream (rgb2dvi-style data/hsync/vsync/vde bundle).
interface rgb_sobel_edge_if;
  logic [23:0] data;
  logic        hsync;
  logic        vsync;
  logic        vde;

  modport master (output data, hsync, vsync, vde);
  modport slave  (input  data, hsync, vsync, vde);
endinterface

// File: rtl/rgb_sobel_edge.sv
// Streaming 3x3 Sobel edge stage: luma -> two line buffers -> |Gx|+|Gy| -> threshold, fixed 4-cycle latency.
// Optional macro SOBEL_OVERLAY_EN: non-edge/border pixels carry the delayed source RGB instead of black.
module rgb_sobel_edge #(
  parameter int H_ACTIVE = 1280,
  parameter int COL_W    = 11,
  parameter int ROW_W    = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_threshold,
  rgb_sobel_edge_if.slave  src,
  rgb_sobel_edge_if.master dst
);
  localparam int STAGES = 3;
  localparam int AW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [COL_W-1:0] COL_LIM = COL_W'(H_ACTIVE);

  logic [STAGES:0] vld_pipe, hs_pipe, vs_pipe;

  // ---------------- position counters ----------------
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row, row_cur;
  logic             vs_rise, vde_fall;

  assign vs_rise  = src.vsync & ~vs_pipe[0];
  assign vde_fall = vld_pipe[0] & ~src.vde;
  // A vsync rise on an active pixel already counts that pixel as row 0.
  assign row_cur  = vs_rise ? '0 : row;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else begin
      if (vde_fall)                       col <= '0;
      else if (src.vde && col < COL_LIM)  col <= col + 1'b1;
      if (vs_rise)                        row <= '0;
      else if (vde_fall && row != '1)     row <= row + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], src.vde};
      hs_pipe  <= {hs_pipe[STAGES-1:0],  src.hsync};
      vs_pipe  <= {vs_pipe[STAGES-1:0],  src.vsync};
    end
  end

  // ---------------- S1: luma ----------------
  logic [16:0]      luma_sum;
  logic [7:0]       y1;
  logic [COL_W-1:0] col1, col2;
  logic [ROW_W-1:0] row1, row2;
  logic             ovl1, ovl2;

  assign luma_sum = 17'd77  * 17'(src.data[23:16])
                  + 17'd150 * 17'(src.data[15:8])
                  + 17'd29  * 17'(src.data[7:0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      y1   <= '0;
      col1 <= '0;
      row1 <= '0;
      ovl1 <= 1'b0;
    end else begin
      y1   <= 8'(luma_sum >> 8);
      col1 <= col;
      row1 <= row_cur;
      ovl1 <= (col >= COL_LIM);
    end
  end

  // ---------------- S2: line buffers + window ----------------
  logic [7:0]           line0 [H_ACTIVE];
  logic [7:0]           line1 [H_ACTIVE];
  logic [2:0][2:0][7:0] win;   // win[row][col]: row 0 = oldest line, col 2 = newest pixel
  logic                 wr1, wr2;
  logic [AW-1:0]        wa1, wa2;

  assign wr1 = vld_pipe[0] & ~ovl1;
  assign wa1 = col1[AW-1:0];

  // line1 takes the old line0 word one cycle later, from the window register that
  // captured it, so each buffer needs only one read and one write port.
  always_ff @(posedge i_clk) begin
    if (wr1) line0[wa1] <= y1;
    if (wr2) line1[wa2] <= win[1][2];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win  <= '0;
      wr2  <= 1'b0;
      wa2  <= '0;
      col2 <= '0;
      row2 <= '0;
      ovl2 <= 1'b0;
    end else begin
      wr2  <= wr1;
      wa2  <= wa1;
      col2 <= col1;
      row2 <= row1;
      ovl2 <= ovl1;
      if (wr1) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= line1[wa1];
        win[1][2] <= line0[wa1];
        win[2][2] <= y1;
      end
    end
  end

  // ---------------- S3: gradients ----------------
  function automatic logic signed [10:0] px(input logic [7:0] v);
    return $signed({3'b000, v});
  endfunction

  logic signed [10:0] gx_c, gy_c, gx3, gy3;
  logic               bord3;

  assign gx_c = (px(win[0][2]) + (px(win[1][2]) <<< 1) + px(win[2][2]))
              - (px(win[0][0]) + (px(win[1][0]) <<< 1) + px(win[2][0]));
  assign gy_c = (px(win[2][0]) + (px(win[2][1]) <<< 1) + px(win[2][2]))
              - (px(win[0][0]) + (px(win[0][1]) <<< 1) + px(win[0][2]));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gx3   <= '0;
      gy3   <= '0;
      bord3 <= 1'b0;
    end else begin
      gx3   <= gx_c;
      gy3   <= gy_c;
      bord3 <= ovl2 | (row2 < ROW_W'(2)) | (col2 < COL_W'(2));
    end
  end

  // ---------------- S4: magnitude, threshold, output ----------------
  function automatic logic [10:0] mag11(input logic signed [10:0] v);
    return v[10] ? $unsigned(-v) : $unsigned(v);
  endfunction

  logic [11:0] mag_c;
  logic        is_edge, hit;
  logic [23:0] fill, pix_q;

  assign mag_c   = {1'b0, mag11(gx3)} + {1'b0, mag11(gy3)};
  assign is_edge = mag_c > {4'd0, i_threshold};
  assign hit     = vld_pipe[2] & ~bord3 & is_edge;

`ifdef SOBEL_OVERLAY_EN
  logic [STAGES-1:0][23:0] rgb_pipe;

  always_ff @(posedge i_clk) begin
    if (i_rst) rgb_pipe <= '0;
    else       rgb_pipe <= {rgb_pipe[STAGES-2:0], src.data};
  end

  assign fill = rgb_pipe[STAGES-1];
`else
  assign fill = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) pix_q <= '0;
    else       pix_q <= hit ? 24'hFFFFFF : fill;
  end

  assign dst.data  = pix_q;
  assign dst.hsync = hs_pipe[STAGES];
  assign dst.vsync = vs_pipe[STAGES];
  assign dst.vde   = vld_pipe[STAGES];
endmodule

// File: tb/tb_rgb_sobel_edge.sv
// Bench for rgb_sobel_edge: table-driven step frames plus random frames against a per-pixel reference model.
module tb_rgb_sobel_edge;
  localparam int H     = 32;
  localparam int ROWS  = 8;
  localparam int SPLIT = 16;
`ifdef SOBEL_OVERLAY_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] thr;

  always #5 clk = ~clk;

  rgb_sobel_edge_if src_if ();
  rgb_sobel_edge_if dst_if ();

  rgb_sobel_edge #(.H_ACTIVE(H), .COL_W(6), .ROW_W(10)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_threshold (thr),
    .src         (src_if.slave),
    .dst         (dst_if.master)
  );

  typedef struct {
    logic [23:0] din;
    logic        hs, vs, vde, rst, valid, skip;
    int          mag;
    logic [7:0]  thr;
  } exp_t;

  typedef struct {
    logic [23:0] lc, rc;
    logic [7:0]  thr;
    bit          horiz;
    int          whites;
  } vec_t;

  exp_t ring [8];
  int   n, n_chk, n_fail, white_cnt;
  // reference model state: counters and per-column luma history of the last two lines
  int   col_m, row_m;
  logic vde_p, vs_p, stale;
  int   h0 [H];
  int   h1 [H];
  int   ct [H][3];

  function automatic int luma(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk_int(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Drive one pixel-clock cycle, model it, and check the output owed from 4 cycles ago.
  task automatic step(input logic [23:0] d, input logic hs, input logic vs, input logic vde, input logic r);
    exp_t e, o;
    int cc, rw, y, gx, gy;
    logic rise, fall, z;
    logic [26:0] got, want;
    logic [7:0] tv;
    rst = r; src_if.data = d; src_if.hsync = hs; src_if.vsync = vs; src_if.vde = vde;
    e = '{din: d, hs: hs, vs: vs, vde: vde, rst: r, valid: 1'b0, skip: 1'b0, mag: 0, thr: thr};
    if (r) begin
      col_m = 0; row_m = 0; vde_p = 1'b0; vs_p = 1'b0; stale = 1'b1;
    end else begin
      rise = vs && !vs_p;
      fall = vde_p && !vde;
      cc = col_m;
      rw = rise ? 0 : row_m;
      if (rise) stale = 1'b0;
      if (vde && cc < H) begin
        y = luma(d);
        ct[cc] = '{h1[cc], h0[cc], y};
        h1[cc] = h0[cc];
        h0[cc] = y;
        if (rw >= 2 && cc >= 2) begin
          gx = (ct[cc][0] + 2 * ct[cc][1] + ct[cc][2]) - (ct[cc-2][0] + 2 * ct[cc-2][1] + ct[cc-2][2]);
          gy = (ct[cc-2][2] + 2 * ct[cc-1][2] + ct[cc][2]) - (ct[cc-2][0] + 2 * ct[cc-1][0] + ct[cc][0]);
          e.mag = iabs(gx) + iabs(gy);
          e.valid = 1'b1;
          e.skip = stale;
        end
      end
      if (vde && col_m < H) col_m++;
      if (fall) col_m = 0;
      if (rise) row_m = 0;
      else if (fall) row_m++;
      vde_p = vde;
      vs_p = vs;
    end
    ring[n % 8] = e;
    @(negedge clk);
    if (n > 0) begin
      o  = ring[(n + 4) % 8];
      tv = ring[(n + 7) % 8].thr;
      z  = 1'b0;
      for (int k = 1; k <= 4; k++) if (ring[(n + 8 - k) % 8].rst) z = 1'b1;
      if (z) want = '0;
      else want = {(o.valid && o.mag > int'(tv)) ? 24'hFFFFFF : (OVL ? o.din : 24'h0), o.hs, o.vs, o.vde};
      got = {dst_if.data, dst_if.hsync, dst_if.vsync, dst_if.vde};
      if (dst_if.vde && dst_if.data == 24'hFFFFFF) white_cnt++;
      if (!z && o.skip) begin
        got[26:3] = '0;
        want[26:3] = '0;
      end
      n_chk++;
      if (got != want) begin
        n_fail++;
        $display("FAIL stream cyc=%0d: got data=%h hs/vs/vde=%b want data=%h hs/vs/vde=%b",
                 n, got[26:3], got[2:0], want[26:3], want[2:0]);
      end
    end
    n++;
    @(posedge clk);
    #1;
  endtask

  // mode 0: fixed two-colour step, 1: full-range random, 2: low-contrast random
  task automatic frame(input logic [23:0] lc, input logic [23:0] rc, input int mode, input bit horiz,
                       input int long_row, input int rst_row, input bit vs_in_line);
    int len;
    logic [23:0] pix;
    for (int i = 0; i < 8; i++) step(24'h0, 1'b0, !vs_in_line && i >= 2 && i < 5, 1'b0, 1'b0);
    for (int r = 0; r < ROWS; r++) begin
      len = (r == long_row) ? H + 4 : H;
      if (mode != 0) len = $urandom_range(H + 3, H - 3);
      for (int c = 0; c < len; c++) begin
        if (mode == 1) begin
          pix = 24'($urandom);
          if ($urandom_range(7) == 0) thr = 8'($urandom);
        end else if (mode == 2) begin
          pix = {8'($urandom_range(63)), 8'($urandom_range(63)), 8'($urandom_range(63))};
          if ($urandom_range(7) == 0) thr = 8'($urandom_range(80));
        end else begin
          pix = horiz ? ((r < 4) ? lc : rc) : ((c < SPLIT) ? lc : rc);
        end
        step(pix, 1'b0, vs_in_line && r == 0 && c < 3, 1'b1, r == rst_row && c >= 10 && c < 13);
      end
      for (int i = 0; i < 6; i++) step(24'h0, i >= 1 && i < 3, 1'b0, 1'b0, 1'b0);
    end
  endtask

  vec_t vec [9];

  initial begin
    vec[0] = '{lc: 24'h808080, rc: 24'h808080, thr: 8'd64,  horiz: 1'b0, whites: 0};
    vec[1] = '{lc: 24'h000000, rc: 24'hFFFFFF, thr: 8'd64,  horiz: 1'b0, whites: 2 * (ROWS - 2)};
    vec[2] = '{lc: 24'h101010, rc: 24'h202020, thr: 8'd64,  horiz: 1'b0, whites: 0};
    vec[3] = '{lc: 24'h101010, rc: 24'h202020, thr: 8'd63,  horiz: 1'b0, whites: 2 * (ROWS - 2)};
    vec[4] = '{lc: 24'hFFFFFF, rc: 24'h000000, thr: 8'd254, horiz: 1'b0, whites: 2 * (ROWS - 2)};
    vec[5] = '{lc: 24'h000000, rc: 24'h010101, thr: 8'd3,   horiz: 1'b0, whites: 2 * (ROWS - 2)};
    vec[6] = '{lc: 24'h000000, rc: 24'h010101, thr: 8'd4,   horiz: 1'b0, whites: 0};
    vec[7] = '{lc: 24'h3366CC, rc: 24'h3366CC, thr: 8'd0,   horiz: 1'b0, whites: 0};
    vec[8] = '{lc: 24'h000000, rc: 24'hFFFFFF, thr: 8'd64,  horiz: 1'b1, whites: 2 * (H - 2)};

    n = 0; n_chk = 0; n_fail = 0; white_cnt = 0;
    col_m = 0; row_m = 0; vde_p = 1'b0; vs_p = 1'b0; stale = 1'b1;
    for (int i = 0; i < H; i++) begin
      h0[i] = 0; h1[i] = 0; ct[i] = '{0, 0, 0};
    end
    for (int i = 0; i < 8; i++) begin
      ring[i] = '{din: 24'h0, hs: 1'b0, vs: 1'b0, vde: 1'b0, rst: 1'b1, valid: 1'b0, skip: 1'b0, mag: 0, thr: 8'd0};
    end
    rst = 1'b1; thr = 8'd64;
    src_if.data = '0; src_if.hsync = 1'b0; src_if.vsync = 1'b0; src_if.vde = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step(24'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 9; i++) begin
      thr = vec[i].thr;
      white_cnt = 0;
      frame(vec[i].lc, vec[i].rc, 0, vec[i].horiz, -1, -1, 1'b0);
`ifndef SOBEL_OVERLAY_EN
      chk_int($sformatf("whites_vec%0d", i), white_cnt, vec[i].whites);
`endif
    end

    // overlong line in the middle of a step frame
    thr = 8'd64;
    white_cnt = 0;
    frame(24'h000000, 24'hFFFFFF, 0, 1'b0, 4, -1, 1'b0);
`ifndef SOBEL_OVERLAY_EN
    chk_int("whites_overlong", white_cnt, 2 * (ROWS - 2));
`endif

    // reset pulse mid-line, then a clean frame
    frame(24'h000000, 24'hFFFFFF, 0, 1'b0, -1, 3, 1'b0);
    white_cnt = 0;
    frame(24'h000000, 24'hFFFFFF, 0, 1'b0, -1, -1, 1'b0);
`ifndef SOBEL_OVERLAY_EN
    chk_int("whites_post_reset", white_cnt, 2 * (ROWS - 2));
`endif

    // vsync rising on an active pixel
    white_cnt = 0;
    frame(24'h000000, 24'hFFFFFF, 0, 1'b0, -1, -1, 1'b1);
`ifndef SOBEL_OVERLAY_EN
    chk_int("whites_vs_in_line", white_cnt, 2 * (ROWS - 2));
`endif

    for (int i = 0; i < 4; i++) begin
      thr = 8'($urandom);
      frame(24'h0, 24'h0, (i % 2) + 1, 1'b0, -1, -1, 1'b0);
    end
    for (int i = 0; i < 6; i++) step(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
